// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared filter state type and default sizing for the fault latch card
package rpsc_pkg;
  typedef enum logic [1:0] {OK, QUAL_ON, FAULT, QUAL_OFF} filt_state_t;
  localparam int DEF_N_CH     = 8;
  localparam int DEF_FILT_CYC = 16;
endpackage

// File: rtl/rpsc_fault_filter.sv
// rpsc_fault_filter: per-channel synchroniser, polarity fix and debounce FSM
// Ports: clk, reset_n (async, active-low), fault_in (raw async input),
//        fault_out (qualified state), rise (fault_out rises at the next edge)
module rpsc_fault_filter import rpsc_pkg::*; #(
  parameter int   FILT_CYC = DEF_FILT_CYC,
  parameter logic POL      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fault_in,
  output logic fault_out,
  output logic rise
);
  logic [1:0] sync;
  filt_state_t st, st_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic s, done;
  assign s = sync[1] ^ POL;
  // The sample that leaves OK/FAULT counts as the first, so the qualifying
  // sample arrives when cnt reaches FILT_CYC-2.
  assign done = (9'(cnt) + 9'd2) >= 9'(FILT_CYC);
  assign cnt_inc = (&cnt) ? cnt : cnt + 8'd1;
  assign fault_out = (st == FAULT) || (st == QUAL_OFF);
  assign rise = (st == QUAL_ON) && s && done;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= {2{POL}};
      st   <= OK;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], fault_in};
      st   <= st_n;
      cnt  <= cnt_n;
    end
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      OK:       if (s) begin st_n = QUAL_ON; cnt_n = '0; end
      QUAL_ON:  if (!s) st_n = OK; else if (done) st_n = FAULT; else cnt_n = cnt_inc;
      FAULT:    if (!s) begin st_n = QUAL_OFF; cnt_n = '0; end
      QUAL_OFF: if (s) st_n = FAULT; else if (done) st_n = OK; else cnt_n = cnt_inc;
    endcase
  end
endmodule

// File: rtl/rpsc_fault_latch_card.sv
// rpsc_fault_latch_card: filtered fault inputs with latched alarms and first-out capture
// Ports: clk, reset_n (async, active-low), fault_in[N_CH] (raw), mask[N_CH],
//        clear (level, acts on rising edge), fault_out, fault_la, alarm_la,
//        first_valid, first_idx
module rpsc_fault_latch_card import rpsc_pkg::*; #(
  parameter int              N_CH     = DEF_N_CH,
  parameter int              FILT_CYC = DEF_FILT_CYC,
  parameter logic [N_CH-1:0] POL      = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         fault_in,
  input  logic [N_CH-1:0]         mask,
  input  logic                    clear,
  output logic [N_CH-1:0]         fault_out,
  output logic [N_CH-1:0]         fault_la,
  output logic                    alarm_la,
  output logic                    first_valid,
  output logic [$clog2(N_CH)-1:0] first_idx
);
  localparam int IW = $clog2(N_CH);
  logic [N_CH-1:0] rise, set, la_n;
  logic clear_q, armed, clr_edge;
  logic [IW-1:0] low_idx;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_fault_filter #(.FILT_CYC(FILT_CYC), .POL(POL[g])) u_filt (
      .clk       (clk),
      .reset_n   (reset_n),
      .fault_in  (fault_in[g]),
      .fault_out (fault_out[g]),
      .rise      (rise[g])
    );
  end
  assign set = rise & ~mask;
  // armed stays low for the first cycle after reset so a clear held through
  // release is not mistaken for a fresh request.
  assign clr_edge = clear & ~clear_q & armed;
  // A new latch wins over a simultaneous clear; clear spares live faults.
  assign la_n = set | (fault_la & ~({N_CH{clr_edge}} & ~fault_out));
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (set[i]) low_idx = IW'(i);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fault_la    <= '0;
      alarm_la    <= 1'b0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      clear_q     <= 1'b0;
      armed       <= 1'b0;
    end else begin
      fault_la <= la_n;
      alarm_la <= |fault_la;
      clear_q  <= clear;
      armed    <= 1'b1;
      if (!first_valid && |set) begin
        first_valid <= 1'b1;
        first_idx   <= low_idx;
      end else if (la_n == '0) first_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rpsc_fault_latch_card.sv
// tb_rpsc_fault_latch_card: directed stimulus with a cycle-tagged expectation scoreboard
module tb_rpsc_fault_latch_card;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] fault_in, mask, fault_out, fault_la;
  logic       clear, alarm_la, first_valid;
  logic [2:0] first_idx;
  int cyc = 0, npass = 0, ntot = 0;
  typedef struct {int cyc; int sel; logic [31:0] v; string nm;} exp_t;
  exp_t sb[$];
  rpsc_fault_latch_card #(.N_CH(8), .FILT_CYC(4), .POL(8'h01)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fault_in    (fault_in),
    .mask        (mask),
    .clear       (clear),
    .fault_out   (fault_out),
    .fault_la    (fault_la),
    .alarm_la    (alarm_la),
    .first_valid (first_valid),
    .first_idx   (first_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] get(int sel);
    case (sel)
      0: return 32'(fault_out);
      1: return 32'(fault_la);
      2: return 32'(alarm_la);
      3: return 32'(first_valid);
      default: return 32'(first_idx);
    endcase
  endfunction
  always @(posedge clk) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        ntot++;
        if (get(sb[i].sel) === sb[i].v) npass++;
        else $display("FAIL %s: got %0h want %0h at cycle %0d", sb[i].nm, get(sb[i].sel), sb[i].v, cyc);
        sb.delete(i);
      end
  end
  task automatic exp(int d, int sel, logic [31:0] v, string nm);
    sb.push_back('{cyc + d, sel, v, nm});
  endtask
  task automatic exp_zero(int d, string nm);
    for (int s = 0; s < 5; s++) exp(d, s, 0, $sformatf("%s_sel%0d", nm, s));
  endtask
  task automatic wt(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0; fault_in = 8'h01; mask = 8'h00; clear = 1'b0;
    wt(2);
    exp_zero(1, "reset");
    wt(1); reset_n = 1'b1;
    wt(3);
    fault_in = 8'h05;
    exp(5, 0, 8'h00, "t1_fo_early");
    exp(6, 0, 8'h04, "t1_fo");
    exp(6, 1, 8'h04, "t1_la");
    exp(6, 3, 1, "t1_fv");
    exp(6, 4, 2, "t1_idx");
    exp(6, 2, 0, "t1_al_lag");
    exp(7, 2, 1, "t1_al");
    wt(8); fault_in = 8'h01;
    exp(6, 0, 8'h00, "t1_fo_fall");
    exp(6, 1, 8'h04, "t1_la_hold");
    wt(6); clear = 1'b1;
    exp(1, 1, 8'h00, "t1_la_clr");
    exp(1, 3, 0, "t1_fv_clr");
    exp(2, 2, 0, "t1_al_clr");
    wt(1); clear = 1'b0;
    wt(2);
    fault_in = 8'h21;
    wt(3); fault_in = 8'h01;
    exp(3, 0, 8'h00, "t2_fo");
    exp(3, 1, 8'h00, "t2_la");
    exp(5, 0, 8'h00, "t2_fo_late");
    wt(6);
    fault_in = 8'h49;
    exp(6, 0, 8'h48, "t3_fo");
    exp(6, 1, 8'h48, "t3_la");
    exp(6, 4, 3, "t3_idx");
    exp(6, 3, 1, "t3_fv");
    wt(8); clear = 1'b1;
    exp(1, 1, 8'h48, "t3_la_kept");
    exp(1, 3, 1, "t3_fv_kept");
    exp(1, 4, 3, "t3_idx_kept");
    wt(1); clear = 1'b0;
    fault_in = 8'h01;
    wt(6); clear = 1'b1;
    exp(1, 1, 8'h00, "t4_la_clr");
    exp(1, 3, 0, "t4_fv_clr");
    exp(1, 2, 1, "t4_al_lag");
    exp(2, 2, 0, "t4_al_clr");
    wt(1); clear = 1'b0;
    wt(2);
    mask = 8'h02; fault_in = 8'h03;
    exp(6, 0, 8'h02, "t5_fo_masked");
    exp(6, 1, 8'h00, "t5_la_masked");
    exp(6, 3, 0, "t5_fv_masked");
    wt(8); fault_in = 8'h02;
    exp(6, 0, 8'h03, "t5_fo_pol");
    exp(6, 1, 8'h01, "t5_la_pol");
    exp(6, 3, 1, "t5_fv_pol");
    exp(6, 4, 0, "t5_idx_pol");
    wt(8); mask = 8'h03;
    exp(2, 1, 8'h01, "t5_mask_keeps");
    wt(3);
    mask = 8'h00; fault_in = 8'h81;
    wt(5); reset_n = 1'b0;
    exp_zero(1, "t6_rst");
    wt(1); clear = 1'b1; reset_n = 1'b1;
    exp(5, 0, 8'h00, "t6_fo_early");
    exp(6, 0, 8'h80, "t6_fo");
    exp(6, 1, 8'h80, "t6_la");
    exp(6, 3, 1, "t6_fv");
    exp(6, 4, 7, "t6_idx");
    wt(8); clear = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    foreach (sb[i]) begin
      ntot++;
      $display("FAIL %s: never checked, want %0h at cycle %0d", sb[i].nm, sb[i].v, sb[i].cyc);
    end
    ntot++;
    if (fault_out === 8'h80) npass++;
    else $display("FAIL end_fo: got %0h want 80", fault_out);
    ntot++;
    if (fault_la === 8'h80) npass++;
    else $display("FAIL end_la: got %0h want 80", fault_la);
    ntot++;
    if (alarm_la === 1'b1) npass++;
    else $display("FAIL end_al: got %0h want 1", alarm_la);
    ntot++;
    if (first_valid === 1'b1) npass++;
    else $display("FAIL end_fv: got %0h want 1", first_valid);
    ntot++;
    if (first_idx === 3'd7) npass++;
    else $display("FAIL end_idx: got %0h want 7", first_idx);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
